// File: rtl/sump_cmd_decoder_pkg.sv
// Shared SUMP command decoder types: opcodes, FSM states, and the completed-command record.
package sump_pkg;

    localparam logic [7:0] OP_RESET = 8'h00;
    localparam logic [7:0] OP_RUN   = 8'h01;
    localparam logic [7:0] OP_ID    = 8'h02;
    localparam logic [7:0] OP_META  = 8'h04;
    localparam logic [7:0] OP_XON   = 8'h11;
    localparam logic [7:0] OP_XOFF  = 8'h13;

    localparam int LONG_BYTES = 4;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] data;
        logic        is_long;
    } cmd_t;

    // Bit 7 of the first byte announces a 4-byte payload.
    function automatic logic is_long_op(input logic [7:0] op);
        return op[7];
    endfunction

endpackage

// File: rtl/sump_cmd_decoder_if.sv
// Receiver-side byte input and decoded command/strobe outputs of the SUMP command decoder.
interface sump_cmd_decoder_if;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_data;
    logic        cmd_is_long;
    logic        sw_reset_stb;
    logic        arm_stb;
    logic        id_stb;
    logic        meta_stb;
    logic        flow_stop;
    logic        timeout_err;

    modport slave (
        input  rx_byte, rx_valid,
        output cmd_valid, cmd_opcode, cmd_data, cmd_is_long,
               sw_reset_stb, arm_stb, id_stb, meta_stb, flow_stop, timeout_err
    );

    modport master (
        output rx_byte, rx_valid,
        input  cmd_valid, cmd_opcode, cmd_data, cmd_is_long,
               sw_reset_stb, arm_stb, id_stb, meta_stb, flow_stop, timeout_err
    );
endinterface

// File: rtl/sump_cmd_decoder_rx_sync_edge.sv
// 2-flop synchronizer plus rising-edge pulse for a slow level from another clock domain.
// Pulse appears combinationally 2 cycles after the level is first sampled; no backpressure.
module rx_sync_edge (
    input  logic input_clk,
    input  logic reset,
    input  logic i_async,
    output logic o_pulse
);
    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge input_clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_async};
            r_prev <= r_sync[1];
        end
    end

    assign o_pulse = r_sync[1] & ~r_prev;
endmodule

// File: rtl/sump_cmd_decoder.sv
// Assembles SUMP short/long host commands from UART bytes; outputs register 1 cycle after the byte strobe.
// No backpressure: every byte is consumed. Optional inter-byte timeout under SUMP_TIMEOUT_EN.
module sump_cmd_decoder #(
    parameter int INPUT_CLK_KHZ = 100_000,
    parameter int TIMEOUT_MS    = 20
) (
    input  logic           input_clk,
    input  logic           reset,
    sump_cmd_decoder_if.slave bus
);
    import sump_pkg::*;

    localparam logic [1:0] LAST_IDX = 2'(LONG_BYTES - 1);

    logic        w_byte_stb;
    logic        w_tmo_hit;
    state_e      r_state;
    logic [1:0]  r_cnt;
    logic [7:0]  r_op;
    logic [23:0] r_shift;
    cmd_t        r_cmd;
    logic        r_cmd_vld;
    logic        r_sw_reset;
    logic        r_arm;
    logic        r_id;
    logic        r_meta;
    logic        r_flow;

    rx_sync_edge u_rx_sync (
        .input_clk (input_clk),
        .reset     (reset),
        .i_async   (bus.rx_valid),
        .o_pulse   (w_byte_stb)
    );

`ifdef SUMP_TIMEOUT_EN
    localparam int TMO_CYCLES = INPUT_CLK_KHZ * TIMEOUT_MS;
    localparam int TW         = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_TC = TW'(TMO_CYCLES - 1);

    logic [TW-1:0] r_timer;
    logic          r_tmo;

    // A byte arriving on the terminal cycle takes priority over the timeout.
    assign w_tmo_hit = (r_state == COLLECT) && (r_timer == TMO_TC) && !w_byte_stb;

    always_ff @(posedge input_clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_tmo <= w_tmo_hit;
            if (r_state == COLLECT && !w_byte_stb && r_timer != TMO_TC)
                r_timer <= r_timer + 1'b1;
            else
                r_timer <= '0;
        end
    end

    assign bus.timeout_err = r_tmo;
`else
    assign w_tmo_hit       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge input_clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= 2'd0;
            r_op       <= 8'h00;
            r_shift    <= 24'h0;
            r_cmd      <= '0;
            r_cmd_vld  <= 1'b0;
            r_sw_reset <= 1'b0;
            r_arm      <= 1'b0;
            r_id       <= 1'b0;
            r_meta     <= 1'b0;
            r_flow     <= 1'b0;
        end else begin
            r_cmd_vld  <= 1'b0;
            r_sw_reset <= 1'b0;
            r_arm      <= 1'b0;
            r_id       <= 1'b0;
            r_meta     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_byte_stb) begin
                        if (is_long_op(bus.rx_byte)) begin
                            r_op    <= bus.rx_byte;
                            r_shift <= 24'h0;
                            r_cnt   <= 2'd0;
                            r_state <= COLLECT;
                        end else begin
                            r_cmd      <= '{opcode: bus.rx_byte, data: 32'h0, is_long: 1'b0};
                            r_cmd_vld  <= 1'b1;
                            r_sw_reset <= (bus.rx_byte == OP_RESET);
                            r_arm      <= (bus.rx_byte == OP_RUN);
                            r_id       <= (bus.rx_byte == OP_ID);
                            r_meta     <= (bus.rx_byte == OP_META);
                            if (bus.rx_byte == OP_XOFF)
                                r_flow <= 1'b1;
                            else if (bus.rx_byte == OP_XON)
                                r_flow <= 1'b0;
                        end
                    end
                end
                COLLECT: begin
                    if (w_byte_stb) begin
                        r_cnt <= r_cnt + 2'd1;
                        // Final byte goes straight into the command; the counter wraps to 0 here.
                        if (r_cnt == LAST_IDX) begin
                            r_cmd     <= '{opcode: r_op, data: {bus.rx_byte, r_shift}, is_long: 1'b1};
                            r_cmd_vld <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_shift[{r_cnt, 3'b000} +: 8] <= bus.rx_byte;
                        end
                    end else if (w_tmo_hit) begin
                        r_cnt   <= 2'd0;
                        r_shift <= 24'h0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_valid    = r_cmd_vld;
    assign bus.cmd_opcode   = r_cmd.opcode;
    assign bus.cmd_data     = r_cmd.data;
    assign bus.cmd_is_long  = r_cmd.is_long;
    assign bus.sw_reset_stb = r_sw_reset;
    assign bus.arm_stb      = r_arm;
    assign bus.id_stb       = r_id;
    assign bus.meta_stb     = r_meta;
    assign bus.flow_stop    = r_flow;
endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Directed-byte bench for sump_cmd_decoder with a byte-stream command model and per-cycle compare.
module tb_sump_cmd_decoder;

    logic input_clk = 1'b0;
    logic reset     = 1'b0;
    int   cyc       = 0;
    int   n_vec     = 0;
    int   n_err     = 0;

    always #5 input_clk = ~input_clk;
    always @(posedge input_clk) cyc <= cyc + 1;

    sump_cmd_decoder_if bus ();

    sump_cmd_decoder #(
        .INPUT_CLK_KHZ (1000),
        .TIMEOUT_MS    (1)
    ) dut (
        .input_clk (input_clk),
        .reset     (reset),
        .bus       (bus)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] d;
        logic        lg;
        logic [3:0]  strb;   // {meta, id, arm, sw_reset}
        logic        flow;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pend[$];
    logic       f_model = 1'b0;
    int         tmo_pending = 0;

    logic [7:0]  m_op   = 8'h00;
    logic [31:0] m_data = 32'h0;
    logic        m_lg   = 1'b0;
    logic        m_flow = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Command model: a byte stream is a sequence of 1-byte short or 5-byte long commands.
    function automatic void model_byte(input logic [7:0] b, input int c);
        exp_t e;
        if (pend.size() == 0 && !b[7]) begin
            e.op   = b;
            e.d    = 32'h0;
            e.lg   = 1'b0;
            e.strb = (b == 8'h00) ? 4'b0001 : (b == 8'h01) ? 4'b0010 :
                     (b == 8'h02) ? 4'b0100 : (b == 8'h04) ? 4'b1000 : 4'b0000;
            if (b == 8'h13) f_model = 1'b1;
            if (b == 8'h11) f_model = 1'b0;
            e.flow = f_model;
            e.cyc  = c + 3;
            exp_q.push_back(e);
        end else begin
            pend.push_back(b);
            if (pend.size() == 5) begin
                e.op   = pend[0];
                e.d    = 32'(pend[1]) + (32'(pend[2]) << 8) + (32'(pend[3]) << 16) + (32'(pend[4]) << 24);
                e.lg   = 1'b1;
                e.strb = 4'b0000;
                e.flow = f_model;
                e.cyc  = c + 3;
                exp_q.push_back(e);
                pend.delete();
            end
        end
    endfunction

    always @(negedge input_clk) begin
        if (!reset) begin
            chk("reset_outputs", {bus.cmd_valid, bus.cmd_opcode, bus.cmd_data, bus.cmd_is_long,
                bus.meta_stb, bus.id_stb, bus.arm_stb, bus.sw_reset_stb, bus.flow_stop, bus.timeout_err}, 64'h0);
            m_op = 8'h00; m_data = 32'h0; m_lg = 1'b0; m_flow = 1'b0;
        end else begin
            if (bus.cmd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_cmd_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("cmd_latency_cycle", cyc, e.cyc);
                    chk("cmd_strobes", {bus.meta_stb, bus.id_stb, bus.arm_stb, bus.sw_reset_stb}, e.strb);
                    m_op = e.op; m_data = e.d; m_lg = e.lg; m_flow = e.flow;
                end
            end else begin
                chk("strobe_without_cmd", {bus.meta_stb, bus.id_stb, bus.arm_stb, bus.sw_reset_stb}, 0);
            end
            chk("cmd_opcode", bus.cmd_opcode, m_op);
            chk("cmd_data", bus.cmd_data, m_data);
            chk("cmd_is_long", bus.cmd_is_long, m_lg);
            chk("flow_stop", bus.flow_stop, m_flow);
            if (bus.timeout_err) begin
                chk("timeout_err_unexpected", tmo_pending != 0, 1);
                if (tmo_pending > 0) tmo_pending--;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge input_clk); #1;
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        model_byte(b, cyc);
        repeat (hold) @(posedge input_clk);
        #1 bus.rx_valid = 1'b0;
        repeat (4) @(posedge input_clk);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge input_clk);
        #1 chk(nm, exp_q.size(), 0);
    endtask

    initial begin
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge input_clk);
        #1 chk("reset_cmd_valid", bus.cmd_valid, 0);
        chk("reset_timeout_err", bus.timeout_err, 0);
        reset = 1'b1;

        send_byte(8'h01, 4);
        drain("drain_arm");
        chk("arm_data_lit", bus.cmd_data, 32'h0);
        chk("arm_opcode_lit", bus.cmd_opcode, 8'h01);

        foreach (pend[i]) pend.delete();
        send_byte(8'h80, 4); send_byte(8'h78, 4); send_byte(8'h56, 4);
        send_byte(8'h34, 4); send_byte(8'h12, 4);
        drain("drain_long1");
        chk("long1_data_lit", bus.cmd_data, 32'h12345678);
        chk("long1_opcode_lit", bus.cmd_opcode, 8'h80);
        chk("long1_is_long_lit", bus.cmd_is_long, 1);

        send_byte(8'hC0, 4); send_byte(8'h00, 4); send_byte(8'h00, 4);
        send_byte(8'h00, 4); send_byte(8'h00, 4);
        drain("drain_long_zero");
        chk("long0_opcode_lit", bus.cmd_opcode, 8'hC0);

        send_byte(8'h81, 4); send_byte(8'h80, 4); send_byte(8'hFF, 4);
        send_byte(8'h00, 4); send_byte(8'h13, 4);
        drain("drain_long_mixed");
        chk("mixed_data_lit", bus.cmd_data, 32'h1300FF80);
        chk("mixed_flow_lit", bus.flow_stop, 0);

        send_byte(8'h13, 4);
        drain("drain_xoff");
        chk("xoff_flow_lit", bus.flow_stop, 1);
        send_byte(8'h11, 4);
        drain("drain_xon");
        chk("xon_flow_lit", bus.flow_stop, 0);
        send_byte(8'h55, 4);
        send_byte(8'h00, 4);
        send_byte(8'h04, 4);
        drain("drain_misc_short");

        send_byte(8'h02, 5000);
        drain("drain_long_hold");
        chk("hold_opcode_lit", bus.cmd_opcode, 8'h02);

        send_byte(8'h13, 4);
        drain("drain_xoff2");
        send_byte(8'h83, 4); send_byte(8'hAA, 4); send_byte(8'hBB, 4);
        @(posedge input_clk); #3;
        reset = 1'b0;
        pend.delete();
        f_model = 1'b0;
        #1 chk("async_rst_flow_lit", bus.flow_stop, 0);
        chk("async_rst_opcode_lit", bus.cmd_opcode, 8'h00);
        repeat (3) @(posedge input_clk);
        #1 reset = 1'b1;
        send_byte(8'h01, 4);
        drain("drain_after_reset");
        chk("after_reset_opcode_lit", bus.cmd_opcode, 8'h01);

`ifdef SUMP_TIMEOUT_EN
        send_byte(8'h82, 4); send_byte(8'hAA, 4);
        tmo_pending = 1;
        pend.delete();
        repeat (900) @(posedge input_clk);
        #1 chk("timeout_not_early", tmo_pending, 1);
        for (int i = 0; i < 300 && tmo_pending != 0; i++) @(posedge input_clk);
        #1 chk("timeout_fired", tmo_pending, 0);
        send_byte(8'h02, 4);
        drain("drain_id_after_tmo");
        chk("tmo_id_opcode_lit", bus.cmd_opcode, 8'h02);
`else
        send_byte(8'h82, 4); send_byte(8'hAA, 4);
        repeat (1100) @(posedge input_clk);
        send_byte(8'hBB, 4); send_byte(8'hCC, 4); send_byte(8'hDD, 4);
        drain("drain_long_after_gap");
        chk("gap_data_lit", bus.cmd_data, 32'hDDCCBBAA);
        chk("gap_opcode_lit", bus.cmd_opcode, 8'h82);
        send_byte(8'h02, 4);
        drain("drain_id_after_gap");
`endif

        repeat (5) @(posedge input_clk);
        #1 chk("final_queue_empty", exp_q.size() + pend.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
